// File: rtl/nabp_angle_sequencer.sv
// Projection angle scheduler: answers swap-controller angle requests with a one-cycle ack.
// Latency: start -> busy next cycle; request -> ack next cycle; pr_done -> done next cycle.
// Backpressure: acks are rate-limited by hs_next_angle (and optional hold, macro NABP_ANGLE_SEQ_HOLD_EN).
module nabp_angle_sequencer #(
    parameter int ANGLE_WIDTH = 9,
    parameter int ANGLE_MOD   = 180,
    parameter int COUNT_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ANGLE_WIDTH-1:0] cfg_angle_start,
    input  logic [ANGLE_WIDTH-1:0] cfg_angle_step,
    input  logic [COUNT_WIDTH-1:0] cfg_num_angles,
    input  logic                   hs_next_angle,
    input  logic                   pr_done,
`ifdef NABP_ANGLE_SEQ_HOLD_EN
    input  logic                   hold,
`endif
    output logic [ANGLE_WIDTH-1:0] hs_angle,
    output logic                   hs_has_next_angle,
    output logic                   hs_next_angle_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   err_cfg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ANGLE_WIDTH:0] MOD_W = (ANGLE_WIDTH + 1)'(ANGLE_MOD);
    localparam logic [COUNT_WIDTH-1:0] ONE_C = COUNT_WIDTH'(1);

    state_t                 state;
    logic [ANGLE_WIDTH-1:0] step_q;
    logic [COUNT_WIDTH-1:0] remaining;

    logic                   hold_act;
    logic                   cfg_bad;
    logic [ANGLE_WIDTH:0]   angle_sum;
    logic [ANGLE_WIDTH-1:0] angle_next;

`ifdef NABP_ANGLE_SEQ_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // Start validation and modular angle step, both extended by one bit to compare against the range bound.
    always_comb begin
        cfg_bad    = (cfg_num_angles == '0)
                   || ({1'b0, cfg_angle_start} >= MOD_W)
                   || ({1'b0, cfg_angle_step} >= MOD_W);
        angle_sum  = {1'b0, hs_angle} + {1'b0, step_q};
        angle_next = hs_angle + step_q;
        if (angle_sum >= MOD_W) begin
            angle_next = ANGLE_WIDTH'(angle_sum - MOD_W);
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            step_q            <= '0;
            remaining         <= '0;
            hs_angle          <= '0;
            hs_has_next_angle <= 1'b0;
            hs_next_angle_ack <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err_cfg           <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;
            case (state)
                IDLE: begin
                    hs_next_angle_ack <= 1'b0;
                    if (start) begin
                        if (cfg_bad) begin
                            err_cfg <= 1'b1;
                        end else begin
                            step_q            <= cfg_angle_step;
                            remaining         <= cfg_num_angles;
                            hs_angle          <= cfg_angle_start;
                            hs_has_next_angle <= 1'b1;
                            busy              <= 1'b1;
                            state             <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (hs_next_angle_ack) begin
                        // Ack cycle ends: step past the angle just issued.
                        hs_next_angle_ack <= 1'b0;
                        hs_angle          <= angle_next;
                        remaining         <= remaining - ONE_C;
                        if (remaining == ONE_C) begin
                            hs_has_next_angle <= 1'b0;
                            state             <= DRAIN;
                        end
                    end else if (hs_next_angle && (remaining != '0) && !hold_act) begin
                        hs_next_angle_ack <= 1'b1;
                    end
                end
                DRAIN: begin
                    hs_next_angle_ack <= 1'b0;
                    if (pr_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state             <= IDLE;
                    busy              <= 1'b0;
                    hs_has_next_angle <= 1'b0;
                    hs_next_angle_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule
